// File: rtl/exe_stage_unit_if.sv
// EX-stage bus: ID/EX fields and freeze in, branch redirect and EX/MEM out.
// master = pipeline/ID side, slave = exe_stage_unit.
interface exe_stage_unit_if;
  logic        freeze;
  logic [31:0] PC_in;
  logic        wb_enable_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        B_in;
  logic        S_in;
  logic        imm_in;
  logic [3:0]  exec_cmd_in;
  logic [31:0] val_Rn_in;
  logic [31:0] val_Rm_in;
  logic [3:0]  Rd_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;

  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        flush_out;
  logic [3:0]  status_out;
  logic        wb_enable_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [31:0] alu_result_out;
  logic [31:0] st_val_out;
  logic [3:0]  Rd_out;

  modport master (
    output freeze, PC_in, wb_enable_in, mem_read_in,
    output mem_write_in, B_in, S_in, imm_in, exec_cmd_in,
    output val_Rn_in, val_Rm_in, Rd_in,
    output shift_operand_in, signed_imm_24_in,
    input  branch_taken, branch_addr, flush_out, status_out,
    input  wb_enable_out, mem_read_out, mem_write_out,
    input  alu_result_out, st_val_out, Rd_out
  );

  modport slave (
    input  freeze, PC_in, wb_enable_in, mem_read_in,
    input  mem_write_in, B_in, S_in, imm_in, exec_cmd_in,
    input  val_Rn_in, val_Rm_in, Rd_in,
    input  shift_operand_in, signed_imm_24_in,
    output branch_taken, branch_addr, flush_out, status_out,
    output wb_enable_out, mem_read_out, mem_write_out,
    output alu_result_out, st_val_out, Rd_out
  );
endinterface

// File: rtl/exe_stage_unit.sv
// Execute stage: Val2 shifter, ALU + NZCV, branch target, EX/MEM register.
// Ports: clk, rst (sync active-low), bus (exe_stage_unit_if.slave).
module exe_stage_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  exe_stage_unit_if.slave bus
);

  logic [11:0] so;
  logic [31:0] val2;
  logic [31:0] imm_base;
  logic [4:0]  imm_rot;
  logic [4:0]  shamt;
  logic [63:0] imm_dbl;
  logic [63:0] rm_dbl;

  assign so       = bus.shift_operand_in;
  assign imm_base = {24'b0, so[7:0]};
  assign imm_rot  = {so[11:8], 1'b0};
  assign shamt    = so[11:7];
  assign imm_dbl  = {imm_base, imm_base} >> imm_rot;
  assign rm_dbl   = {bus.val_Rm_in, bus.val_Rm_in} >> shamt;

  always_comb begin
    val2 = bus.val_Rm_in;
    if (bus.mem_read_in || bus.mem_write_in) begin
      val2 = {20'b0, so};
    end else if (bus.imm_in) begin
      val2 = imm_dbl[31:0];
    end else begin
      unique case (so[6:5])
        2'b00: val2 = bus.val_Rm_in << shamt;
        2'b01: val2 = bus.val_Rm_in >> shamt;
        2'b10: val2 = $unsigned($signed(bus.val_Rm_in) >>> shamt);
        2'b11: val2 = rm_dbl[31:0];
        default: val2 = bus.val_Rm_in;
      endcase
    end
  end

  logic [3:0]  status;
  logic        c_in;
  logic [31:0] a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [32:0] sum;
  logic [31:0] result;
  logic        arith;
  logic        known;
  logic [3:0]  nzcv;

  assign c_in = status[1];
  assign a    = bus.val_Rn_in;

  // One shared adder; subtracts use A + ~B + carry.
  always_comb begin
    add_b   = val2;
    add_cin = 1'b0;
    unique case (bus.exec_cmd_in)
      4'b0011: add_cin = c_in;
      4'b0100,
      4'b1100: begin
        add_b   = ~val2;
        add_cin = 1'b1;
      end
      4'b0101: begin
        add_b   = ~val2;
        add_cin = c_in;
      end
      default: begin
        add_b   = val2;
        add_cin = 1'b0;
      end
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, add_b} + {32'b0, add_cin};

  always_comb begin
    result = '0;
    arith  = 1'b0;
    known  = 1'b1;
    unique case (bus.exec_cmd_in)
      4'b0001: result = val2;
      4'b1001: result = ~val2;
      4'b0010,
      4'b0011,
      4'b0100,
      4'b0101,
      4'b1100: begin
        result = sum[31:0];
        arith  = 1'b1;
      end
      4'b0110,
      4'b1110: result = a & val2;
      4'b0111: result = a | val2;
      4'b1000: result = a ^ val2;
      default: begin
        result = '0;
        known  = 1'b0;
      end
    endcase
  end

  always_comb begin
    nzcv = status;
    if (known) begin
      nzcv[3] = result[31];
      nzcv[2] = (result == 32'b0);
      if (arith) begin
        nzcv[1] = sum[32];
        nzcv[0] = (a[31] == add_b[31]) && (result[31] != a[31]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      status <= '0;
    end else if (bus.S_in && !bus.freeze) begin
      status <= nzcv;
    end
  end

  assign bus.status_out   = status;
  assign bus.branch_taken = bus.B_in;
  assign bus.flush_out    = bus.B_in;
  assign bus.branch_addr  = bus.PC_in +
    {{6{bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.wb_enable_out  <= 1'b0;
      bus.mem_read_out   <= 1'b0;
      bus.mem_write_out  <= 1'b0;
      bus.alu_result_out <= '0;
      bus.st_val_out     <= '0;
      bus.Rd_out         <= '0;
    end else if (!bus.freeze) begin
      bus.wb_enable_out  <= bus.wb_enable_in;
      bus.mem_read_out   <= bus.mem_read_in;
      bus.mem_write_out  <= bus.mem_write_in;
      bus.alu_result_out <= result;
      bus.st_val_out     <= bus.val_Rm_in;
      bus.Rd_out         <= bus.Rd_in;
    end
  end

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed bench for exe_stage_unit.
// Checks reset, ALU/flags, shifter, branch and freeze.
module tb_exe_stage_unit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  exe_stage_unit_if bus ();

  exe_stage_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [3:0]  cmd,
                     input logic        s,
                     input logic        im,
                     input logic        mr,
                     input logic        mw,
                     input logic        wb,
                     input logic [31:0] rn,
                     input logic [31:0] rm,
                     input logic [11:0] sop,
                     input logic [3:0]  rd);
    bus.exec_cmd_in      = cmd;
    bus.S_in             = s;
    bus.imm_in           = im;
    bus.mem_read_in      = mr;
    bus.mem_write_in     = mw;
    bus.wb_enable_in     = wb;
    bus.val_Rn_in        = rn;
    bus.val_Rm_in        = rm;
    bus.shift_operand_in = sop;
    bus.Rd_in            = rd;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus.freeze           = 1'b1;
    bus.PC_in            = 32'h0000_0040;
    bus.B_in             = 1'b0;
    bus.signed_imm_24_in = 24'h00_0010;
    ins(4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
        32'hDEAD_BEEF, 32'h1357_9BDF, 12'hABC, 4'hF);

    tick;
    tick;
    chk("rst_wb",     {31'b0, bus.wb_enable_out}, 32'h0);
    chk("rst_mr",     {31'b0, bus.mem_read_out},  32'h0);
    chk("rst_mw",     {31'b0, bus.mem_write_out}, 32'h0);
    chk("rst_alu",    bus.alu_result_out,         32'h0);
    chk("rst_st",     bus.st_val_out,             32'h0);
    chk("rst_rd",     {28'b0, bus.Rd_out},        32'h0);
    chk("rst_status", {28'b0, bus.status_out},    32'h0);

    rst        = 1'b1;
    bus.freeze = 1'b0;

    ins(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
        32'h7FFF_FFFF, 32'h0000_1234, 12'h001, 4'h3);
    tick;
    chk("add_res",    bus.alu_result_out,         32'h8000_0000);
    chk("add_nzcv",   {28'b0, bus.status_out},    32'h9);
    chk("add_st",     bus.st_val_out,             32'h0000_1234);
    chk("add_rd",     {28'b0, bus.Rd_out},        32'h3);
    chk("add_wb",     {31'b0, bus.wb_enable_out}, 32'h1);

    ins(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        32'h5, 32'h5, 12'h000, 4'h4);
    tick;
    chk("sub_res",  bus.alu_result_out,      32'h0);
    chk("sub_nzcv", {28'b0, bus.status_out}, 32'h6);

    ins(4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
        32'h3, 32'h0, 12'h002, 4'h5);
    tick;
    chk("sbc_res",  bus.alu_result_out,      32'h1);
    chk("sbc_nzcv", {28'b0, bus.status_out}, 32'h2);

    ins(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
        32'h0, 32'h0, 12'h4FF, 4'h6);
    tick;
    chk("imm_rot", bus.alu_result_out, 32'hFF00_0000);

    ins(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
        32'h0, 32'h8000_0000, 12'h240, 4'h6);
    tick;
    chk("asr4", bus.alu_result_out, 32'hF800_0000);

    ins(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
        32'h0, 32'h0000_0001, 12'h0E0, 4'h6);
    tick;
    chk("ror1",   bus.alu_result_out,      32'h8000_0000);
    chk("s0_hold", {28'b0, bus.status_out}, 32'h2);

    ins(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
        32'h0000_1000, 32'h0, 12'hFFF, 4'h7);
    tick;
    chk("ldr_addr", bus.alu_result_out,        32'h0000_1FFF);
    chk("ldr_mr",   {31'b0, bus.mem_read_out}, 32'h1);

    ins(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
        32'hF0F0_F0F0, 32'h0F0F_0F0F, 12'h000, 4'h8);
    tick;
    chk("and_res",  bus.alu_result_out,      32'h0);
    chk("and_nzcv", {28'b0, bus.status_out}, 32'h6);
    chk("and_mr",   {31'b0, bus.mem_read_out}, 32'h0);

    bus.B_in             = 1'b1;
    bus.PC_in            = 32'h0000_0100;
    bus.signed_imm_24_in = 24'hFF_FFFE;
    #1;
    chk("br_addr",  bus.branch_addr,           32'h0000_00F8);
    chk("br_taken", {31'b0, bus.branch_taken}, 32'h1);
    chk("br_flush", {31'b0, bus.flush_out},    32'h1);
    bus.B_in = 1'b0;
    #1;
    chk("br_idle", {31'b0, bus.branch_taken}, 32'h0);

    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
          32'hFFFF_FFF0 + i, 32'hA5A5_0000 + i, 12'h0FF, 4'h9);
      tick;
      chk("frz_alu",    bus.alu_result_out,      32'h0);
      chk("frz_status", {28'b0, bus.status_out}, 32'h6);
      chk("frz_rd",     {28'b0, bus.Rd_out},     32'h8);
    end
    bus.B_in = 1'b1;
    #1;
    chk("frz_br", {31'b0, bus.branch_taken}, 32'h1);
    bus.B_in = 1'b0;

    bus.freeze = 1'b0;
    ins(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
        32'h0000_000A, 32'h0000_00AA, 12'h005, 4'hA);
    tick;
    chk("rel_alu",    bus.alu_result_out,      32'h0000_000F);
    chk("rel_status", {28'b0, bus.status_out}, 32'h0);
    chk("rel_rd",     {28'b0, bus.Rd_out},     32'hA);
    chk("rel_st",     bus.st_val_out,          32'h0000_00AA);

    rst        = 1'b0;
    bus.freeze = 1'b1;
    tick;
    chk("rst2_alu", bus.alu_result_out,         32'h0);
    chk("rst2_wb",  {31'b0, bus.wb_enable_out}, 32'h0);
    chk("rst2_rd",  {28'b0, bus.Rd_out},        32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
